// File: rtl/makina_pkg.sv
// makina_pkg: shared widths, port ids and read-tag type for the data memory arbiter
package makina_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;
  typedef struct packed {
    logic valid;
    logic port;
    logic oob;
  } rd_tag_t;
endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: saturating count of consecutive cycles port 1 waited; force when it hits MAX_WAIT
module arb_wait_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_force
);
  localparam logic [7:0] MAX = 8'(MAX_WAIT);
  logic [7:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (!i_req || i_gnt) r_cnt <= '0;
    else if (r_cnt != MAX) r_cnt <= r_cnt + 8'd1;
  assign o_force = r_cnt == MAX;
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port 1-cycle-latency RAM between the CPU (p0) and an aux master (p1)
module data_mem_arbiter import makina_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_DEPTH = 64,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              oob_err
);
  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);
  logic              w_force, w_p1_win, w_any, w_we, w_inr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata, w_rd;
  rd_tag_t           r_tag;
  logic              r_oob;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;

  arb_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (p1_req),
    .i_gnt   (p1_gnt),
    .o_force (w_force)
  );

  always_comb begin
    w_p1_win  = rst_n && p1_req && (!p0_req || w_force);
    p1_gnt    = w_p1_win;
    p0_gnt    = rst_n && p0_req && !w_p1_win;
    w_any     = p0_gnt || p1_gnt;
    w_we      = w_p1_win ? p1_we : p0_we;
    w_addr    = w_p1_win ? p1_addr : p0_addr;
    w_wdata   = w_p1_win ? p1_wdata : p0_wdata;
    w_inr     = w_addr < DEPTH;
    mem_en    = w_any && w_inr;
    mem_we    = w_any && w_we;
    mem_addr  = w_any ? w_addr : '0;
    mem_wdata = w_any ? w_wdata : '0;
    w_rd      = r_tag.oob ? '0 : mem_rdata;
  end

  // rdata follows the RAM in the response cycle and holds the last response otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_tag    <= '0;
      r_oob    <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_tag    <= '{valid: w_any && !w_we, port: w_p1_win, oob: !w_inr};
      r_oob    <= w_any && !w_inr;
      if (p0_rvalid) r_rdata0 <= w_rd;
      if (p1_rvalid) r_rdata1 <= w_rd;
    end

  assign p0_rvalid = r_tag.valid && r_tag.port == PORT_CPU;
  assign p1_rvalid = r_tag.valid && r_tag.port == PORT_AUX;
  assign p0_rdata  = p0_rvalid ? w_rd : r_rdata0;
  assign p1_rdata  = p1_rvalid ? w_rd : r_rdata1;
  assign oob_err   = r_oob;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: table-driven arbitration vectors with a scoreboard of expected read responses
module tb_data_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [15:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_en, mem_we, oob_err;
  logic [15:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ram [64];
  logic [15:0] ref_ram [64];
  logic [15:0] last0 = '0, last1 = '0;
  int          errors = 0, checks = 0;

  typedef struct {
    logic p0r, p0w; logic [15:0] a0, d0;
    logic p1r, p1w; logic [15:0] a1, d1;
    logic g0, g1, en;
  } vec_t;
  typedef struct {
    logic rv0, rv1, oob;
    logic [15:0] d0, d1;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[$];

  data_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
      else mem_rdata <= ram[mem_addr[5:0]];
    end

  function automatic vec_t mk(int p0r, int p0w, int a0, int d0, int p1r, int p1w, int a1, int d1,
                              int g0, int g1, int en);
    mk = '{1'(p0r), 1'(p0w), 16'(a0), 16'(d0), 1'(p1r), 1'(p1w), 16'(a1), 16'(d1),
           1'(g0), 1'(g1), 1'(en)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input vec_t v);
    exp_t e;
    logic [15:0] a, wd, rd;
    logic we, any, inr;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("p0_rvalid", 32'(p0_rvalid), 32'(e.rv0));
      chk("p1_rvalid", 32'(p1_rvalid), 32'(e.rv1));
      chk("p0_rdata", 32'(p0_rdata), 32'(e.d0));
      chk("p1_rdata", 32'(p1_rdata), 32'(e.d1));
      chk("oob_err", 32'(oob_err), 32'(e.oob));
    end
    p0_req = v.p0r; p0_we = v.p0w; p0_addr = v.a0; p0_wdata = v.d0;
    p1_req = v.p1r; p1_we = v.p1w; p1_addr = v.a1; p1_wdata = v.d1;
    #1;
    chk("p0_gnt", 32'(p0_gnt), 32'(v.g0));
    chk("p1_gnt", 32'(p1_gnt), 32'(v.g1));
    chk("mem_en", 32'(mem_en), 32'(v.en));
    any = v.g0 | v.g1;
    a   = v.g1 ? v.a1 : v.a0;
    wd  = v.g1 ? v.d1 : v.d0;
    we  = v.g1 ? v.p1w : v.p0w;
    inr = a < 16'd64;
    chk("mem_addr", 32'(mem_addr), 32'(any ? a : 16'h0));
    chk("mem_we", 32'(mem_we), 32'(any && we));
    chk("mem_wdata", 32'(mem_wdata), 32'(any ? wd : 16'h0));
    rd = inr ? ref_ram[a[5:0]] : 16'h0;
    e.rv0 = v.g0 && !v.p0w;
    e.rv1 = v.g1 && !v.p1w;
    e.oob = any && !inr;
    if (e.rv0) last0 = rd;
    if (e.rv1) last1 = rd;
    e.d0 = last0;
    e.d1 = last1;
    if (any && we && inr) ref_ram[a[5:0]] = wd;
    sb.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i]     = 16'(i * 7 + 5);
      ref_ram[i] = 16'(i * 7 + 5);
    end
    // p0 read of addr 0 (holds 5), idle, p1 write then p0 read-back
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 3, 'hBEEF, 0, 1, 1));
    tbl.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0, 1, 0, 1));
    // alternating single-port reads
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 2, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 4, 0, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 5, 0, 0, 1, 1));
    // out of range write and read at 70, then addr 6 (70 aliased) must be untouched
    tbl.push_back(mk(1, 1, 70, 'h1234, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 70, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 6, 0, 0, 0, 0, 0, 1, 0, 1));
    // both request every cycle: p1 forced through on every 5th cycle
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1, 0, 10 + i, 0, 1, 0, 20 + i, 0,
                       (i % 5 != 4), (i % 5 == 4), 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    p0_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst p0_gnt", 32'(p0_gnt), 0);
    chk("rst mem_en", 32'(mem_en), 0);
    chk("rst p0_rvalid", 32'(p0_rvalid), 0);
    chk("rst p0_rdata", 32'(p0_rdata), 0);
    chk("rst oob_err", 32'(oob_err), 0);
    p0_req = 1'b0;
    rst_n  = 1'b1;

    foreach (tbl[i]) cycle(tbl[i]);

    // p1 read granted, then reset asserted before the capturing edge
    @(negedge clk);
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'd7;
    #1 chk("pre-rst p1_gnt", 32'(p1_gnt), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("in-rst p1_gnt", 32'(p1_gnt), 0);
    chk("in-rst mem_en", 32'(mem_en), 0);
    chk("in-rst mem_addr", 32'(mem_addr), 0);
    chk("in-rst p0_rdata", 32'(p0_rdata), 0);
    chk("in-rst p1_rdata", 32'(p1_rdata), 0);
    repeat (2) begin
      @(negedge clk);
      chk("in-rst p1_rvalid", 32'(p1_rvalid), 0);
      chk("in-rst oob_err", 32'(oob_err), 0);
    end
    p1_req = 1'b0;
    rst_n  = 1'b1;
    sb.delete();
    last0 = '0;
    last1 = '0;
    #1 chk("post-rst p1_rvalid", 32'(p1_rvalid), 0);
    repeat (2) cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(mk(0, 0, 0, 0, 1, 0, 9, 0, 0, 1, 1));
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
